// File: rtl/mem_arbiter.sv
// Purpose: arbitrates one pipelined unified memory between I-fetch and D paths (block fills, single-word writes).
// Latency: grant one cycle after req is sampled; fill issues BURST reads back-to-back, done with the BURST-th mem_valid.
// Backpressure: requesters hold req until done; memory stalls are absorbed by the receive counter. Build option: MEM_ARB_RR_EN.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int BURST   = 8,
  parameter int MEM_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req,
  input  logic [ADDR_W-1:0]        i_addr,
  output logic                     i_grant,
  output logic                     i_data_valid,
  output logic                     i_done,
  input  logic                     d_req,
  input  logic                     d_wr,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [DATA_W-1:0]        d_wdata,
  output logic                     d_grant,
  output logic                     d_data_valid,
  output logic                     d_done,
  output logic [$clog2(BURST)-1:0] word_idx,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_valid
);

  localparam int IDX_W = $clog2(BURST);
  localparam int ISS_W = IDX_W + 1;
  // Clears the byte offset within a 2*BURST-byte block.
  localparam logic [ADDR_W-1:0] BLK_MASK = ~(ADDR_W'(2 * BURST - 1));

  // A zero-latency memory would return data in the issue cycle, which the receive path does not expect.
  if (MEM_LAT < 1) begin : g_lat_chk
    $error("mem_arbiter: MEM_LAT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

  state_t            state;
  logic [ISS_W-1:0]  iss_cnt;
  logic [IDX_W-1:0]  rcv_cnt;
  logic [ADDR_W-1:0] base;
  logic              pick_d;
  logic              in_fill;
  logic              issuing;
  logic              fill_vld;
  logic              fill_last;

`ifdef MEM_ARB_RR_EN
  // Set when D owned the memory most recently; reset value means I.
  logic last_d;

  // On a tie, hand the memory to whichever side did not have it last.
  always_comb pick_d = d_req & (~i_req | ~last_d);
`else
  // Data side always wins ties.
  always_comb pick_d = d_req;
`endif

  // Decode fill progress from state and counters.
  always_comb begin
    in_fill   = (state == I_FILL) || (state == D_FILL);
    issuing   = in_fill && (iss_cnt < ISS_W'(BURST));
    fill_vld  = in_fill && mem_valid;
    fill_last = fill_vld && (rcv_cnt == IDX_W'(BURST - 1));
  end

  // Arbitration, block base capture, issue/receive counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      iss_cnt <= '0;
      rcv_cnt <= '0;
      base    <= '0;
`ifdef MEM_ARB_RR_EN
      last_d  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          iss_cnt <= '0;
          rcv_cnt <= '0;
          if (pick_d) begin
            state <= d_wr ? D_WRITE : D_FILL;
            base  <= d_addr & BLK_MASK;
`ifdef MEM_ARB_RR_EN
            last_d <= 1'b1;
`endif
          end else if (i_req) begin
            state <= I_FILL;
            base  <= i_addr & BLK_MASK;
`ifdef MEM_ARB_RR_EN
            last_d <= 1'b0;
`endif
          end
        end
        I_FILL, D_FILL: begin
          if (issuing)   iss_cnt <= iss_cnt + 1'b1;
          if (fill_vld)  rcv_cnt <= rcv_cnt + 1'b1;
          if (fill_last) state   <= IDLE;
        end
        D_WRITE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Requester-facing outputs; valids are gated by state so stray mem_valid in IDLE is dropped.
  always_comb begin
    i_grant      = (state == I_FILL);
    d_grant      = (state == D_FILL) || (state == D_WRITE);
    i_data_valid = (state == I_FILL) && mem_valid;
    d_data_valid = (state == D_FILL) && mem_valid;
    i_done       = (state == I_FILL) && fill_last;
    d_done       = ((state == D_FILL) && fill_last) || (state == D_WRITE);
    word_idx     = fill_vld ? rcv_cnt : '0;
    rd_data      = fill_vld ? mem_rdata : '0;
  end

  // Memory-facing outputs; address and write data are forced to 0 whenever no access is issued.
  always_comb begin
    mem_en    = issuing || (state == D_WRITE);
    mem_wr    = (state == D_WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (issuing) begin
      mem_addr = base + (ADDR_W'(iss_cnt) << 1);
    end else if (state == D_WRITE) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: pipelined memory model with optional stalls, event monitor, per-scenario checks.
// Expected results come from a transaction-level model (owner order, block word lists).
// Timing checks are relative to the cycle in which requests are raised.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int ADDR_W = 16, DATA_W = 16, BURST = 8, MEM_LAT = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_grant, i_data_valid, i_done, d_grant, d_data_valid, d_done;
  logic [2:0]  word_idx;
  logic [15:0] rd_data, mem_addr, mem_wdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_rdata = '0;
  logic        mem_valid = 1'b0;
  logic [58:0] all_out;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data_valid(i_data_valid), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_grant(d_grant),
    .d_data_valid(d_data_valid), .d_done(d_done), .word_idx(word_idx), .rd_data(rd_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  assign all_out = {i_grant, d_grant, i_data_valid, d_data_valid, i_done, d_done, word_idx,
                    rd_data, mem_en, mem_wr, mem_addr, mem_wdata};

  typedef struct {int cyc; logic [15:0] a; logic [15:0] d; int idx; logic done;} ev_t;
  typedef struct {int due; logic [15:0] a;} rd_t;

  ev_t rd_q[$], wr_q[$], iv_q[$], dv_q[$];
  rd_t pend_q[$];
  ev_t mon_e;
  rd_t mon_r;
  int  cyc = 0, last_vld = -100, gap_mode = 0, viol = 0;
  int  n_checks = 0, n_pass = 0;
  bit  last_d = 1'b0;  // model of the most recent owner (1 = D)

  // Memory contents: a fixed function of the byte address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] blk(input logic [15:0] a);
    return a - (a % 16);
  endfunction

  // Pipelined memory: each read returns MEM_LAT cycles after issue, later if stalled.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc &&
        (gap_mode == 0 || (gap_mode == 1 && cyc - last_vld >= 3) ||
         (gap_mode == 2 && $urandom_range(0, 2) != 0))) begin
      mem_valid = 1'b1;
      mem_rdata = mem_word(pend_q[0].a);
      last_vld  = cyc;
      void'(pend_q.pop_front());
    end else begin
      mem_valid = 1'b0;
      mem_rdata = 16'($urandom);
    end
  end

  // Monitor: record memory accesses and returned words, flag invariant breaks.
  always @(negedge clk) begin
    if (mem_en && !mem_wr) begin
      mon_r.due = cyc + MEM_LAT; mon_r.a = mem_addr; pend_q.push_back(mon_r);
      mon_e.cyc = cyc; mon_e.a = mem_addr; mon_e.d = '0; mon_e.idx = 0; mon_e.done = 1'b0;
      rd_q.push_back(mon_e);
    end
    if (mem_en && mem_wr) begin
      mon_e.cyc = cyc; mon_e.a = mem_addr; mon_e.d = mem_wdata; mon_e.idx = 0; mon_e.done = d_done;
      wr_q.push_back(mon_e);
    end
    if (i_data_valid) begin
      mon_e.cyc = cyc; mon_e.a = '0; mon_e.d = rd_data; mon_e.idx = int'(word_idx); mon_e.done = i_done;
      iv_q.push_back(mon_e);
    end
    if (d_data_valid) begin
      mon_e.cyc = cyc; mon_e.a = '0; mon_e.d = rd_data; mon_e.idx = int'(word_idx); mon_e.done = d_done;
      dv_q.push_back(mon_e);
    end
    if (!mem_en && (mem_addr != 0 || mem_wdata != 0 || mem_wr)) viol++;
    if (!i_data_valid && !d_data_valid && (rd_data != 0 || word_idx != 0)) viol++;
    if (i_grant && d_grant) viol++;
    if (i_done && !i_data_valid) viol++;
    if (d_done && !d_data_valid && !(mem_en && mem_wr)) viol++;
  end

  // Drive one transaction (one or both requesters) until every raised request is done.
  task automatic run_txn(input bit do_i, input bit do_d, input bit dwr, input bit early,
                         input logic [15:0] ia, input logic [15:0] da, input logic [15:0] dw,
                         output int c0, output int ig, output int dg, output int idn, output int ddn,
                         output int ign, output int dgn, output bit tmo);
    int t;
    bit ip, dp;
    @(negedge clk);
    rd_q.delete(); wr_q.delete(); iv_q.delete(); dv_q.delete();
    c0 = cyc; ig = -1; dg = -1; idn = -1; ddn = -1; ign = 0; dgn = 0; t = 0;
    i_addr = ia; d_addr = da; d_wdata = dw; d_wr = dwr; i_req = do_i; d_req = do_d;
    ip = do_i; dp = do_d;
    while ((ip || dp) && t < 200) begin
      @(negedge clk);
      t++;
      if (i_grant) begin ign++; if (ig < 0) ig = cyc; end
      if (d_grant) begin dgn++; if (dg < 0) dg = cyc; end
      if (i_done) begin idn = cyc; ip = 1'b0; i_req = 1'b0; end
      if (d_done) begin ddn = cyc; dp = 1'b0; d_req = 1'b0; end
      if (early && i_grant) i_req = 1'b0;
      if (early && d_grant) d_req = 1'b0;
    end
    tmo = ip || dp;
    i_req = 1'b0; d_req = 1'b0;
    repeat (MEM_LAT + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    int c0;
    bit seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (all_out !== '0) $display("FAIL reset_hold: outputs %h, want 0", all_out); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (all_out !== '0) $display("FAIL reset_release_idle: outputs %h, want 0", all_out); else n_pass++;
    i_addr = 16'h0500; i_req = 1'b1; c0 = cyc;
    repeat (7) @(negedge clk);
    n_checks++;
    if (i_grant !== 1'b1 || i_data_valid !== 1'b1 || word_idx !== 3'd2)
      $display("FAIL reset_pre_fill: grant %b valid %b idx %0d, want 1 1 2", i_grant, i_data_valid, word_idx);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (all_out !== '0) $display("FAIL reset_async: outputs %h, want 0", all_out); else n_pass++;
    i_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (i_grant || d_grant || i_data_valid || d_data_valid || mem_en) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL reset_abort_idle: activity %b, want 0", seen); else n_pass++;
    last_d = 1'b0;
  endtask

  task automatic test_i_fill();
    int c0, ig, dg, idn, ddn, ign, dgn;
    bit tmo;
    gap_mode = 0;
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h1236, 16'h0, 16'h0, c0, ig, dg, idn, ddn, ign, dgn, tmo);
    n_checks++; if (tmo !== 1'b0) $display("FAIL ifill_timeout: got %b want 0", tmo); else n_pass++;
    n_checks++; if (ig !== c0 + 1) $display("FAIL ifill_grant_cyc: got %0d want %0d", ig - c0, 1); else n_pass++;
    n_checks++; if (idn !== c0 + 12) $display("FAIL ifill_done_cyc: got %0d want %0d", idn - c0, 12); else n_pass++;
    n_checks++; if (ign !== 12) $display("FAIL ifill_grant_len: got %0d want 12", ign); else n_pass++;
    n_checks++; if (rd_q.size() !== 8 || iv_q.size() !== 8)
      $display("FAIL ifill_counts: reads %0d words %0d, want 8 8", rd_q.size(), iv_q.size()); else n_pass++;
    for (int k = 0; k < 8 && k < rd_q.size() && k < iv_q.size(); k++) begin
      n_checks++;
      if (rd_q[k].cyc !== c0 + 1 + k || rd_q[k].a !== 16'h1230 + 16'(2 * k))
        $display("FAIL ifill_issue%0d: cyc %0d addr %h, want %0d %h", k, rd_q[k].cyc - c0, rd_q[k].a, 1 + k, 16'h1230 + 16'(2 * k));
      else n_pass++;
      n_checks++;
      if (iv_q[k].cyc !== c0 + 5 + k || iv_q[k].idx !== k || iv_q[k].d !== mem_word(16'h1230 + 16'(2 * k)) ||
          iv_q[k].done !== (k == 7))
        $display("FAIL ifill_word%0d: cyc %0d idx %0d data %h done %b, want %0d %0d %h %b", k, iv_q[k].cyc - c0,
                 iv_q[k].idx, iv_q[k].d, iv_q[k].done, 5 + k, k, mem_word(16'h1230 + 16'(2 * k)), k == 7);
      else n_pass++;
    end
    last_d = 1'b0;
  endtask

  task automatic test_d_write();
    int c0, ig, dg, idn, ddn, ign, dgn;
    bit tmo;
    gap_mode = 0;
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0042, 16'hBEEF, c0, ig, dg, idn, ddn, ign, dgn, tmo);
    n_checks++; if (tmo !== 1'b0) $display("FAIL dwrite_timeout: got %b want 0", tmo); else n_pass++;
    n_checks++; if (dg !== c0 + 1 || ddn !== c0 + 1 || dgn !== 1)
      $display("FAIL dwrite_timing: grant %0d done %0d len %0d, want 1 1 1", dg - c0, ddn - c0, dgn); else n_pass++;
    n_checks++; if (wr_q.size() !== 1 || rd_q.size() !== 0)
      $display("FAIL dwrite_counts: writes %0d reads %0d, want 1 0", wr_q.size(), rd_q.size()); else n_pass++;
    if (wr_q.size() > 0) begin
      n_checks++;
      if (wr_q[0].cyc !== c0 + 1 || wr_q[0].a !== 16'h0042 || wr_q[0].d !== 16'hBEEF || wr_q[0].done !== 1'b1)
        $display("FAIL dwrite_access: cyc %0d addr %h data %h done %b, want 1 0042 beef 1",
                 wr_q[0].cyc - c0, wr_q[0].a, wr_q[0].d, wr_q[0].done);
      else n_pass++;
    end
    last_d = 1'b1;
  endtask

  task automatic test_priority();
    int c0, ig, dg, idn, ddn, ign, dgn, fg, fd, sg;
    bit tmo, d_first;
    logic [15:0] ia;
    gap_mode = 0;
    ia = 16'($urandom);
    d_first = !(RR && last_d);
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, ia, 16'h2000, 16'h0, c0, ig, dg, idn, ddn, ign, dgn, tmo);
    fg = d_first ? dg : ig; fd = d_first ? ddn : idn; sg = d_first ? ig : dg;
    n_checks++; if (tmo !== 1'b0) $display("FAIL prio_timeout: got %b want 0", tmo); else n_pass++;
    n_checks++; if (fg !== c0 + 1 || fd !== c0 + 12)
      $display("FAIL prio_first: grant %0d done %0d (d_first %b), want 1 12", fg - c0, fd - c0, d_first); else n_pass++;
    n_checks++; if (sg !== c0 + 14) $display("FAIL prio_second_grant: got %0d want 14", sg - c0); else n_pass++;
    n_checks++; if (dv_q.size() !== 8 || iv_q.size() !== 8)
      $display("FAIL prio_words: d %0d i %0d, want 8 8", dv_q.size(), iv_q.size()); else n_pass++;
    for (int k = 0; k < 8 && k < dv_q.size() && k < iv_q.size(); k++) begin
      n_checks++;
      if (dv_q[k].d !== mem_word(16'h2000 + 16'(2 * k)) || iv_q[k].d !== mem_word(blk(ia) + 16'(2 * k)))
        $display("FAIL prio_data%0d: d %h i %h, want %h %h", k, dv_q[k].d, iv_q[k].d,
                 mem_word(16'h2000 + 16'(2 * k)), mem_word(blk(ia) + 16'(2 * k)));
      else n_pass++;
    end
    last_d = !d_first;
  endtask

  task automatic test_stall();
    int c0, ig, dg, idn, ddn, ign, dgn;
    bit tmo;
    logic [15:0] da;
    gap_mode = 1;
    da = 16'($urandom);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, da, 16'h0, c0, ig, dg, idn, ddn, ign, dgn, tmo);
    gap_mode = 0;
    n_checks++; if (tmo !== 1'b0) $display("FAIL stall_timeout: got %b want 0", tmo); else n_pass++;
    n_checks++; if (dv_q.size() !== 8) $display("FAIL stall_count: got %0d want 8", dv_q.size()); else n_pass++;
    for (int k = 0; k < dv_q.size(); k++) begin
      n_checks++;
      if (dv_q[k].idx !== k || dv_q[k].done !== (k == 7) || dv_q[k].d !== mem_word(blk(da) + 16'(2 * k)))
        $display("FAIL stall_word%0d: idx %0d done %b data %h, want %0d %b %h", k, dv_q[k].idx, dv_q[k].done,
                 dv_q[k].d, k, k == 7, mem_word(blk(da) + 16'(2 * k)));
      else n_pass++;
    end
    if (dv_q.size() == 8) begin
      n_checks++; if (ddn !== dv_q[7].cyc || ddn < c0 + 12 + 14)
        $display("FAIL stall_done_cyc: got %0d want %0d (>= 26)", ddn - c0, dv_q[7].cyc - c0); else n_pass++;
    end
    n_checks++; if (rd_q.size() !== 8 || (rd_q.size() == 8 && rd_q[7].cyc !== c0 + 8))
      $display("FAIL stall_issue: reads %0d, want 8 ending at cycle 8", rd_q.size()); else n_pass++;
    last_d = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int kind, c0, ig, dg, idn, ddn, ign, dgn, fg, fd, sg;
      bit do_i, do_d, dwr, early, tmo, d_first;
      logic [15:0] ia, da, dw;
      logic [15:0] exp_i[$], exp_d[$], exp_rd[$];
      exp_i.delete(); exp_d.delete(); exp_rd.delete();
      kind  = $urandom_range(0, 4);
      do_i  = (kind == 0) || (kind >= 3);
      do_d  = (kind != 0);
      dwr   = (kind == 2) || (kind == 4);
      early = (kind < 3) && ($urandom_range(0, 1) == 1);
      ia = 16'($urandom); da = 16'($urandom); dw = 16'($urandom);
      gap_mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      d_first = do_d && (!do_i || !(RR && last_d));
      for (int k = 0; k < BURST; k++) begin
        if (do_i) exp_i.push_back(blk(ia) + 16'(2 * k));
        if (do_d && !dwr) exp_d.push_back(blk(da) + 16'(2 * k));
      end
      if (d_first) begin exp_rd = exp_d; foreach (exp_i[k]) exp_rd.push_back(exp_i[k]); end
      else begin exp_rd = exp_i; foreach (exp_d[k]) exp_rd.push_back(exp_d[k]); end
      last_d = (do_i && do_d) ? !d_first : do_d;

      run_txn(do_i, do_d, dwr, early, ia, da, dw, c0, ig, dg, idn, ddn, ign, dgn, tmo);
      fg = d_first ? dg : ig; fd = d_first ? ddn : idn; sg = d_first ? ig : dg;

      n_checks++; if (tmo !== 1'b0) $display("FAIL rnd%0d_timeout: got %b want 0", n, tmo); else n_pass++;
      n_checks++; if (fg !== c0 + 1) $display("FAIL rnd%0d_first_grant: got %0d want 1", n, fg - c0); else n_pass++;
      if (do_i && do_d) begin
        n_checks++; if (sg !== fd + 2) $display("FAIL rnd%0d_second_grant: got %0d want %0d", n, sg - c0, fd + 2 - c0); else n_pass++;
      end
      if (gap_mode == 0) begin
        n_checks++; if (fd !== c0 + ((d_first && dwr) ? 1 : 12))
          $display("FAIL rnd%0d_first_done: got %0d want %0d", n, fd - c0, (d_first && dwr) ? 1 : 12); else n_pass++;
      end
      n_checks++; if (rd_q.size() !== exp_rd.size())
        $display("FAIL rnd%0d_reads: got %0d want %0d", n, rd_q.size(), exp_rd.size()); else n_pass++;
      for (int k = 0; k < rd_q.size() && k < exp_rd.size(); k++) begin
        n_checks++; if (rd_q[k].a !== exp_rd[k])
          $display("FAIL rnd%0d_raddr%0d: got %h want %h", n, k, rd_q[k].a, exp_rd[k]); else n_pass++;
      end
      n_checks++; if (iv_q.size() !== exp_i.size() || dv_q.size() !== exp_d.size())
        $display("FAIL rnd%0d_words: i %0d d %0d, want %0d %0d", n, iv_q.size(), dv_q.size(), exp_i.size(), exp_d.size());
      else n_pass++;
      for (int k = 0; k < iv_q.size() && k < exp_i.size(); k++) begin
        n_checks++;
        if (iv_q[k].d !== mem_word(exp_i[k]) || iv_q[k].idx !== k || iv_q[k].done !== (k == BURST - 1))
          $display("FAIL rnd%0d_iword%0d: data %h idx %0d done %b, want %h %0d %b", n, k, iv_q[k].d, iv_q[k].idx,
                   iv_q[k].done, mem_word(exp_i[k]), k, k == BURST - 1);
        else n_pass++;
      end
      for (int k = 0; k < dv_q.size() && k < exp_d.size(); k++) begin
        n_checks++;
        if (dv_q[k].d !== mem_word(exp_d[k]) || dv_q[k].idx !== k || dv_q[k].done !== (k == BURST - 1))
          $display("FAIL rnd%0d_dword%0d: data %h idx %0d done %b, want %h %0d %b", n, k, dv_q[k].d, dv_q[k].idx,
                   dv_q[k].done, mem_word(exp_d[k]), k, k == BURST - 1);
        else n_pass++;
      end
      n_checks++; if (wr_q.size() !== int'(do_d && dwr))
        $display("FAIL rnd%0d_writes: got %0d want %0d", n, wr_q.size(), int'(do_d && dwr)); else n_pass++;
      if (wr_q.size() == 1) begin
        n_checks++; if (wr_q[0].a !== da || wr_q[0].d !== dw || dgn !== 1)
          $display("FAIL rnd%0d_wdata: addr %h data %h len %0d, want %h %h 1", n, wr_q[0].a, wr_q[0].d, dgn, da, dw);
        else n_pass++;
      end
    end
    gap_mode = 0;
    n_checks++; if (viol !== 0) $display("FAIL invariants: %0d violations, want 0", viol); else n_pass++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_i_fill();
    test_d_write();
    test_priority();
    test_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
